// File: rtl/mem_pkg.sv
// Shared types and default sizes for the memory-port arbiter.
package mem_pkg;

    localparam int ADDR_WIDTH   = 16;
    localparam int WIDTH        = 32;
    localparam int STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } resp_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating starvation counter: clear has priority, increments stop at LIMIT.
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] cnt,
    output logic       at_limit
);

    localparam logic [3:0] LIM = 4'(LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (inc && cnt != LIM) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store; data wins
// unless a pending fetch has lost STARVE_LIMIT times in a row.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_WIDTH,
    parameter int DATA_W       = WIDTH,
    parameter int STARVE_LIMIT = mem_pkg::STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              if_starved_o
);

    resp_t      resp_q;
    resp_t      resp_d;
    logic       at_limit;
    logic       starve_force;
    logic [3:0] starve_cnt;

    starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (d_gnt_o && if_req_i),
        .clr     (if_gnt_o || !if_req_i),
        .cnt     (starve_cnt),
        .at_limit(at_limit)
    );

    always_comb begin
        starve_force = if_req_i && d_req_i && at_limit;
        if_gnt_o     = rst_n && if_req_i && (!d_req_i || starve_force);
        d_gnt_o      = rst_n && d_req_i && !starve_force;
        if_starved_o = rst_n && starve_force;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        resp_d       = NONE;
        if (if_gnt_o) begin
            mem_read_o = 1'b1;
            mem_addr_o = if_addr_i;
            resp_d     = RESP_IF;
        end else if (d_gnt_o) begin
            mem_read_o  = !d_we_i;
            mem_write_o = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            resp_d      = d_we_i ? NONE : RESP_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q <= NONE;
        end else begin
            resp_q <= resp_d;
        end
    end

    assign if_rvalid_o = (resp_q == RESP_IF);
    assign d_rvalid_o  = (resp_q == RESP_D);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural one-cycle memory.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        is_d;
        logic [31:0] data;
    } resp_e_t;

    logic        clk;
    logic        rst_n;
    logic        if_req_i;
    logic [15:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [15:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        if_starved_o;

    int      checks = 0;
    int      errors = 0;
    resp_e_t sb[$];
    logic    exp_if_rv = 1'b0;
    logic    exp_d_rv  = 1'b0;

    logic [31:0] mem_arr [0:65535];
    bit          mem_ready = 1'b0;

    mem_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .if_starved_o(if_starved_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory preloaded with C0DE_<addr>; writes land at the edge
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) begin
                mem_arr[i] <= 32'hC0DE0000 | 32'(i);
            end
            mem_ready   <= 1'b1;
            mem_rdata_i <= 32'h0;
        end else begin
            if (mem_write_o) mem_arr[mem_addr_o] <= mem_wdata_o;
            if (mem_read_o) mem_rdata_i <= mem_arr[mem_addr_o];
        end
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (if_rvalid_o || d_rvalid_o) begin
            resp_e_t e;
            checks++;
            if (if_rvalid_o && d_rvalid_o) begin
                errors++;
                $display("FAIL both_rvalid: got 1/1 expected one");
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rvalid: got if=%b d=%b expected none",
                         if_rvalid_o, d_rvalid_o);
            end else begin
                e = sb.pop_front();
                if (e.is_d != d_rvalid_o) begin
                    errors++;
                    $display("FAIL resp_owner: got d=%b expected d=%b",
                             d_rvalid_o, e.is_d);
                end else if ((e.is_d ? d_rdata_o : if_rdata_o) !== e.data) begin
                    errors++;
                    $display("FAIL resp_data: got %h expected %h",
                             e.is_d ? d_rdata_o : if_rdata_o, e.data);
                end
            end
        end
    end

    task automatic step(input logic ir, input logic [15:0] ia,
                        input logic dr, input logic dw,
                        input logic [15:0] da, input logic [31:0] dwd,
                        input logic eig, input logic edg, input logic est,
                        input logic [31:0] erd);
        if_req_i  = ir;
        if_addr_i = ia;
        d_req_i   = dr;
        d_we_i    = dw;
        d_addr_i  = da;
        d_wdata_i = dwd;
        #3;
        chk("if_rvalid", 32'(if_rvalid_o), 32'(exp_if_rv));
        chk("d_rvalid", 32'(d_rvalid_o), 32'(exp_d_rv));
        if (!exp_if_rv) chk("if_rdata_idle", if_rdata_o, 32'h0);
        if (!exp_d_rv) chk("d_rdata_idle", d_rdata_o, 32'h0);
        chk("if_gnt", 32'(if_gnt_o), 32'(eig));
        chk("d_gnt", 32'(d_gnt_o), 32'(edg));
        chk("if_starved", 32'(if_starved_o), 32'(est));
        if (eig) begin
            chk("mem_rd_if", 32'(mem_read_o), 32'h1);
            chk("mem_wr_if", 32'(mem_write_o), 32'h0);
            chk("mem_addr_if", 32'(mem_addr_o), 32'(ia));
            sb.push_back('{is_d: 1'b0, data: erd});
        end else if (edg) begin
            chk("mem_rd_d", 32'(mem_read_o), 32'(!dw));
            chk("mem_wr_d", 32'(mem_write_o), 32'(dw));
            chk("mem_addr_d", 32'(mem_addr_o), 32'(da));
            chk("mem_wdata_d", mem_wdata_o, dwd);
            if (!dw) sb.push_back('{is_d: 1'b1, data: erd});
        end else begin
            chk("mem_idle", {mem_read_o, mem_write_o, mem_addr_o},
                32'h0);
            chk("mem_wdata_idle", mem_wdata_o, 32'h0);
        end
        exp_if_rv = eig;
        exp_d_rv  = edg && !dw;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 16'h0, 0, 0, 16'h0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    task automatic starve_run(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 5 == 4)
                step(1, 16'h0004, 1, 0, 16'h1000, 32'h0,
                     1, 0, 1, 32'hC0DE0004);
            else
                step(1, 16'h0004, 1, 0, 16'h1000, 32'h0,
                     0, 1, 0, 32'hC0DE1000);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        if_req_i  = 1'b0;
        if_addr_i = 16'h0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = 16'h0;
        d_wdata_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_rvalid", 32'(if_rvalid_o), 32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid_o), 32'h0);
        chk("rst_starved", 32'(if_starved_o), 32'h0);
        chk("rst_rdata", if_rdata_o | d_rdata_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        idle();
        step(1, 16'h0010, 0, 0, 16'h0, 32'h0, 1, 0, 0, 32'hC0DE0010);
        idle();

        step(0, 16'h0, 1, 1, 16'h1004, 32'hDEADBEEF, 0, 1, 0, 32'h0);
        step(0, 16'h0, 1, 0, 16'h1004, 32'h0, 0, 1, 0, 32'hDEADBEEF);
        idle();

        step(0, 16'h0, 1, 0, 16'h1000, 32'h0, 0, 1, 0, 32'hC0DE1000);
        step(1, 16'h0004, 0, 0, 16'h0, 32'h0, 1, 0, 0, 32'hC0DE0004);
        step(0, 16'h0, 1, 0, 16'h1008, 32'h0, 0, 1, 0, 32'hC0DE1008);
        idle();

        starve_run(10);
        idle();

        step(0, 16'h0, 1, 1, 16'hFFF0, 32'h00001234, 0, 1, 0, 32'h0);
        idle();

        // Reset lands while the fetch response is outstanding
        step(1, 16'h0010, 0, 0, 16'h0, 32'h0, 1, 0, 0, 32'hC0DE0010);
        rst_n    = 1'b0;
        if_req_i = 1'b1;
        d_req_i  = 1'b1;
        #3;
        chk("rstmid_if_rvalid", 32'(if_rvalid_o), 32'h0);
        chk("rstmid_if_rdata", if_rdata_o, 32'h0);
        chk("rstmid_gnt", {30'h0, if_gnt_o, d_gnt_o}, 32'h0);
        chk("rstmid_mem", {30'h0, mem_read_o, mem_write_o}, 32'h0);
        sb.delete();
        @(negedge clk);
        if_req_i = 1'b0;
        d_req_i  = 1'b0;
        rst_n    = 1'b1;
        exp_if_rv = 1'b0;
        exp_d_rv  = 1'b0;
        @(posedge clk);
        #1;
        starve_run(5);
        idle();
        idle();

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
